// File: rtl/player_sequence_checker_pkg.sv
// Shared Simon game definitions: response-checker FSM states, the maximum
// sequence length and the button index constants. The sequence generator and
// the LED/frequency maps use the same button encoding.
package player_sequence_checker_pkg;

    // Entries in the sequence memory (longest round).
    localparam int unsigned MAX_LEN = 10;

    // Button indices as produced by the button interpreter.
    localparam logic [1:0] BTN_GREEN  = 2'd0;
    localparam logic [1:0] BTN_RED    = 2'd1;
    localparam logic [1:0] BTN_YELLOW = 2'd2;
    localparam logic [1:0] BTN_BLUE   = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT_PRESS,
        S_WAIT_RELEASE,
        S_OK,
        S_FAIL
    } chk_state_t;

endpackage

// File: rtl/player_sequence_checker_press_edge_detect.sv
// press_edge_detect: registers the player_pressed level and produces
// single-cycle rise/fall pulses against the previous cycle's value.
// Ports:
//   clk     in  system clock
//   reset   in  asynchronous, active-low reset
//   pressed in  button-held level from the interpreter
//   rise    out high in the cycle pressed goes 0->1
//   fall    out high in the cycle pressed goes 1->0
module press_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic pressed,
    output logic rise,
    output logic fall
);

    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= pressed;
        end
    end

    assign rise = pressed & ~prev;
    assign fall = ~pressed & prev;

endmodule

// File: rtl/player_sequence_checker.sv
// player_sequence_checker: response side of a Simon round. After playback it
// walks the stored sequence and checks each player press against it,
// reporting round success, a wrong button or an input timeout.
// Ports:
//   clk            in  system clock
//   reset          in  asynchronous, active-low reset
//   start          in  1-cycle pulse, begin checking a round (IDLE only)
//   seq_len        in  entries to check, latched on start (0 or >MAX_LEN = MAX_LEN)
//   rd_addr        out sequence memory read address
//   rd_data        in  memory data, valid 1 clk after rd_addr (registered read)
//   player_num     in  button index from the interpreter
//   player_pressed in  level, high while a button is held
//   busy           out high from accepted start until round_ok/game_over
//   round_ok       out 1-cycle pulse, all presses matched
//   game_over      out level, wrong press or timeout; held until next start
//   timeout        out level, game_over cause was timeout (0 = wrong button)
//   index          out number of correct presses so far this round
module player_sequence_checker #(
    parameter int unsigned MAX_LEN        = player_sequence_checker_pkg::MAX_LEN,
    parameter int unsigned ADDR_W         = 4,
    parameter int unsigned TIMEOUT_CYCLES = 250000000,
    parameter int unsigned TO_W           = 28
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] seq_len,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [1:0]        rd_data,
    input  logic [1:0]        player_num,
    input  logic              player_pressed,
    output logic              busy,
    output logic              round_ok,
    output logic              game_over,
    output logic              timeout,
    output logic [ADDR_W-1:0] index
);

    import player_sequence_checker_pkg::*;

    localparam logic [ADDR_W-1:0] LEN_MAX = ADDR_W'(MAX_LEN);
    localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    chk_state_t        state_q, state_d;
    logic [ADDR_W-1:0] len_q, len_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [1:0]        expected_q, expected_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              game_over_q, game_over_d;
    logic              timeout_q, timeout_d;
    logic [ADDR_W-1:0] len_eff;
    logic              press_rise;
    logic              press_fall;

    press_edge_detect u_edge (
        .clk     (clk),
        .reset   (reset),
        .pressed (player_pressed),
        .rise    (press_rise),
        .fall    (press_fall)
    );

    assign len_eff = (seq_len == '0 || seq_len > LEN_MAX) ? LEN_MAX : seq_len;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            len_q       <= '0;
            addr_q      <= '0;
            index_q     <= '0;
            expected_q  <= '0;
            to_cnt_q    <= '0;
            game_over_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            addr_q      <= addr_d;
            index_q     <= index_d;
            expected_q  <= expected_d;
            to_cnt_q    <= to_cnt_d;
            game_over_q <= game_over_d;
            timeout_q   <= timeout_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        addr_d      = addr_q;
        index_d     = index_q;
        expected_d  = expected_q;
        to_cnt_d    = to_cnt_q;
        game_over_d = game_over_q;
        timeout_d   = timeout_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d       = len_eff;
                    addr_d      = '0;
                    index_d     = '0;
                    game_over_d = 1'b0;
                    timeout_d   = 1'b0;
                    state_d     = S_FETCH;
                end
            end
            S_FETCH: begin
                expected_d = rd_data;
                to_cnt_d   = '0;
                state_d    = S_WAIT_PRESS;
            end
            S_WAIT_PRESS: begin
                // A press edge takes priority over an expiring timeout.
                if (press_rise) begin
                    if (player_num == expected_q) begin
                        state_d = S_WAIT_RELEASE;
                    end else begin
                        game_over_d = 1'b1;
                        timeout_d   = 1'b0;
                        state_d     = S_FAIL;
                    end
                end else if (to_cnt_q == TO_LAST) begin
                    game_over_d = 1'b1;
                    timeout_d   = 1'b1;
                    state_d     = S_FAIL;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WAIT_RELEASE: begin
                // Entered only from a cycle with the button high, so the
                // fall pulse is exactly the first cycle the button reads low.
                if (press_fall) begin
                    index_d = index_q + 1'b1;
                    if (index_d == len_q) begin
                        state_d = S_OK;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            S_OK:    state_d = S_IDLE;
            S_FAIL:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // The memory registers its address, so the next address is presented a
    // cycle early; the data then lands in the FETCH cycle where it is captured.
    assign rd_addr   = addr_d;
    assign busy      = (state_q == S_FETCH) || (state_q == S_WAIT_PRESS) ||
                       (state_q == S_WAIT_RELEASE);
    assign round_ok  = (state_q == S_OK);
    assign game_over = game_over_q;
    assign timeout   = timeout_q;
    assign index     = index_q;

endmodule

// File: tb/tb_player_sequence_checker.sv
// Directed bench for player_sequence_checker with a registered-read sequence
// memory model and a 100-cycle press timeout.
module tb_player_sequence_checker;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] seq_len;
    logic [3:0] rd_addr;
    logic [1:0] rd_data;
    logic [1:0] player_num;
    logic       player_pressed;
    logic       busy;
    logic       round_ok;
    logic       game_over;
    logic       timeout;
    logic [3:0] index;

    logic [1:0] mem [16];
    int vectors     = 0;
    int miscompares = 0;
    int ok_pulses   = 0;
    int ok_before;

    player_sequence_checker #(
        .MAX_LEN        (10),
        .ADDR_W         (4),
        .TIMEOUT_CYCLES (100),
        .TO_W           (28)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .seq_len        (seq_len),
        .rd_addr        (rd_addr),
        .rd_data        (rd_data),
        .player_num     (player_num),
        .player_pressed (player_pressed),
        .busy           (busy),
        .round_ok       (round_ok),
        .game_over      (game_over),
        .timeout        (timeout),
        .index          (index)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    always @(negedge clk) if (round_ok) ok_pulses++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [3:0] len);
        start   = 1'b1;
        seq_len = len;
        tick();
        start = 1'b0;
    endtask

    task automatic press_hold(input logic [1:0] num);
        player_num     = num;
        player_pressed = 1'b1;
        repeat (3) tick();
    endtask

    task automatic release_btn();
        player_pressed = 1'b0;
        tick();
    endtask

    task automatic press(input logic [1:0] num);
        press_hold(num);
        release_btn();
        tick();
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; seq_len = '0;
        player_num = '0; player_pressed = 1'b0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        repeat (2) tick();
        chk("rst_busy", busy, 0);
        chk("rst_round_ok", round_ok, 0);
        chk("rst_game_over", game_over, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_index", index, 0);
        chk("rst_rd_addr", rd_addr, 0);
        reset = 1'b1;
        tick();

        // 1: correct round of three
        mem[0] = 2'd2; mem[1] = 2'd0; mem[2] = 2'd3;
        ok_before = ok_pulses;
        do_start(4'd3);
        chk("t1_busy", busy, 1);
        tick();
        press(2'd2);
        chk("t1_index1", index, 1);
        press(2'd0);
        chk("t1_index2", index, 2);
        press_hold(2'd3);
        release_btn();
        chk("t1_round_ok_latency", round_ok, 1);
        chk("t1_index3", index, 3);
        tick();
        chk("t1_round_ok_drop", round_ok, 0);
        chk("t1_busy_end", busy, 0);
        chk("t1_game_over", game_over, 0);
        chk("t1_ok_pulses", ok_pulses - ok_before, 1);

        // 2: wrong second button
        mem[0] = 2'd1; mem[1] = 2'd1;
        ok_before = ok_pulses;
        do_start(4'd2);
        tick();
        press(2'd1);
        player_num     = 2'd2;
        player_pressed = 1'b1;
        tick();
        chk("t2_game_over_now", game_over, 1);
        repeat (2) tick();
        chk("t2_game_over", game_over, 1);
        chk("t2_timeout", timeout, 0);
        chk("t2_index", index, 1);
        chk("t2_busy", busy, 0);
        chk("t2_no_round_ok", ok_pulses - ok_before, 0);
        release_btn();
        tick();

        // 3: timeout with no press
        mem[0] = 2'd3;
        do_start(4'd1);
        chk("t3_go_cleared", game_over, 0);
        tick();
        repeat (99) tick();
        chk("t3_no_timeout_yet", game_over, 0);
        chk("t3_busy_before", busy, 1);
        tick();
        chk("t3_game_over", game_over, 1);
        chk("t3_timeout", timeout, 1);
        tick();
        chk("t3_busy_after", busy, 0);
        chk("t3_go_held", game_over, 1);

        // 4: button held across start is not a press
        mem[0] = 2'd3;
        ok_before = ok_pulses;
        player_num     = 2'd3;
        player_pressed = 1'b1;
        repeat (2) tick();
        do_start(4'd1);
        chk("t4_timeout_cleared", timeout, 0);
        tick();
        repeat (5) tick();
        chk("t4_held_busy", busy, 1);
        chk("t4_held_index", index, 0);
        release_btn();
        chk("t4_release_no_ok", round_ok, 0);
        chk("t4_release_busy", busy, 1);
        tick();
        press_hold(2'd3);
        release_btn();
        chk("t4_round_ok", round_ok, 1);
        chk("t4_index", index, 1);
        tick();
        chk("t4_ok_pulses", ok_pulses - ok_before, 1);

        // 5: reset mid WAIT_RELEASE at index 2
        mem[0] = 2'd0; mem[1] = 2'd1; mem[2] = 2'd2;
        do_start(4'd3);
        tick();
        press(2'd0);
        press(2'd1);
        press_hold(2'd2);
        chk("t5_pre_index", index, 2);
        chk("t5_pre_rd_addr", rd_addr, 2);
        #2 reset = 1'b0;
        #1;
        chk("t5_rst_busy", busy, 0);
        chk("t5_rst_index", index, 0);
        chk("t5_rst_rd_addr", rd_addr, 0);
        chk("t5_rst_game_over", game_over, 0);
        player_pressed = 1'b0;
        tick();
        #3 reset = 1'b1;
        tick();
        do_start(4'd3);
        chk("t5_restart_rd_addr", rd_addr, 0);
        chk("t5_restart_index", index, 0);
        tick();
        press(2'd0);
        chk("t5_restart_index1", index, 1);
        press(2'd1);
        press_hold(2'd2);
        release_btn();
        chk("t5_round_ok", round_ok, 1);
        tick();

        // 6: seq_len=0 means ten entries; start while busy is ignored
        for (int i = 0; i < 10; i++) mem[i] = 2'(i % 4);
        ok_before = ok_pulses;
        do_start(4'd0);
        tick();
        press(2'd0);
        press(2'd1);
        do_start(4'd3);
        chk("t6_busy_start_index", index, 2);
        chk("t6_busy_start_busy", busy, 1);
        for (int i = 2; i < 9; i++) press(mem[i]);
        chk("t6_index9", index, 9);
        chk("t6_no_early_ok", ok_pulses - ok_before, 0);
        press_hold(2'd1);
        release_btn();
        chk("t6_round_ok", round_ok, 1);
        chk("t6_index10", index, 10);
        chk("t6_rd_addr_last", rd_addr, 9);
        tick();
        chk("t6_ok_pulses", ok_pulses - ok_before, 1);
        chk("t6_game_over", game_over, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
